// File: rtl/pe_loader_pkg.sv
// Shared types and helpers for the PE cluster loader.
package pe_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WGHT,
        IACT,
        COMPUTE,
        DONE
    } state_e;

    // Width of one iact_choose field: enough for every channel index plus the idle code.
    function automatic int unsigned choose_w(input int unsigned num_iact);
        return $clog2(num_iact + 1);
    endfunction

    // Code that routes no iact channel to a PE.
    function automatic int unsigned idle_code(input int unsigned num_iact);
        return num_iact;
    endfunction

endpackage

// File: rtl/pe_loader_chan.sv
// One-entry output register for a multi-channel stream: channels advance in
// lockstep, and accepted/transferred beats are counted against a fixed limit.
module pe_loader_chan #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WORD_W   = 24,
    parameter int unsigned LIMIT    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         active,
    input  logic                         clear,
    input  logic [CHANNELS*WORD_W-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CHANNELS*WORD_W-1:0]   out_data,
    output logic [CHANNELS-1:0]          enable,
    input  logic [CHANNELS-1:0]          pe_ready,
    output logic                         xfer,
    output logic                         last
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic             out_valid;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] xfer_cnt;
    logic             accept;

    assign xfer     = out_valid && (&pe_ready);
    assign last     = xfer && (xfer_cnt == CNT_W'(LIMIT - 1));
    assign in_ready = active && (acc_cnt < CNT_W'(LIMIT)) && (!out_valid || xfer);
    assign accept   = in_ready && in_valid;
    assign enable   = {CHANNELS{out_valid}};

    // Output register and beat counters; clear discards any buffered word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            acc_cnt   <= '0;
            xfer_cnt  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            acc_cnt   <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                acc_cnt   <= acc_cnt + CNT_W'(1);
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (xfer) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pe_cluster_loader.sv
// Sequencer streaming weights then diagonal iact passes into a PE cluster,
// followed by a compute pulse. Optional stall watchdog: PE_LOADER_WATCHDOG_EN.
module pe_cluster_loader
    import pe_loader_pkg::*;
#(
    parameter int unsigned PE_ROWS             = 3,
    parameter int unsigned PE_COLUMNS          = 4,
    parameter int unsigned NUM_GLB_IACT        = 3,
    parameter int unsigned NUM_GLB_WGHT        = 3,
    parameter int unsigned TRANS_BITWIDTH_IACT = 24,
    parameter int unsigned TRANS_BITWIDTH_WGHT = 24,
    parameter int unsigned WGHT_ADDR_WORDS     = 1,
    parameter int unsigned WGHT_DATA_WORDS     = 96,
    parameter int unsigned IACT_ADDR_WORDS     = 1,
    parameter int unsigned IACT_DATA_WORDS     = 8,
    parameter int unsigned IACT_DIAGONALS      = 2,
    parameter int unsigned WDOG_CYCLES         = 256
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_i,
    input  logic                                                   start_i,
    output logic                                                   busy_o,
    output logic                                                   done_o,
    output logic                                                   err_o,
    input  logic [NUM_GLB_WGHT*TRANS_BITWIDTH_WGHT-1:0]            wght_in_data_i,
    input  logic                                                   wght_in_valid_i,
    output logic                                                   wght_in_ready_o,
    input  logic [NUM_GLB_IACT*TRANS_BITWIDTH_IACT-1:0]            iact_in_data_i,
    input  logic                                                   iact_in_valid_i,
    output logic                                                   iact_in_ready_o,
    output logic [NUM_GLB_WGHT*TRANS_BITWIDTH_WGHT-1:0]            pe_wght_data_o,
    output logic [NUM_GLB_WGHT-1:0]                                pe_wght_enable_o,
    input  logic [NUM_GLB_WGHT-1:0]                                pe_wght_ready_i,
    output logic [NUM_GLB_IACT*TRANS_BITWIDTH_IACT-1:0]            pe_iact_data_o,
    output logic [NUM_GLB_IACT-1:0]                                pe_iact_enable_o,
    input  logic [NUM_GLB_IACT-1:0]                                pe_iact_ready_i,
    output logic [PE_COLUMNS*PE_ROWS*choose_w(NUM_GLB_IACT)-1:0]   iact_choose_o,
    output logic [PE_COLUMNS*PE_ROWS-1:0]                          compute_o
);

    localparam int unsigned NUM_PE    = PE_COLUMNS * PE_ROWS;
    localparam int unsigned CHOOSE_W  = choose_w(NUM_GLB_IACT);
    localparam int unsigned IDLE_CODE = idle_code(NUM_GLB_IACT);
    localparam int unsigned DIAG_W    = $clog2(IACT_DIAGONALS + 1);

    state_e                     state_q;
    state_e                     state_n;
    logic [DIAG_W-1:0]          diag_q;
    logic [DIAG_W-1:0]          diag_n;
    logic                       wght_xfer;
    logic                       wght_last;
    logic                       wght_clear;
    logic                       iact_xfer;
    logic                       iact_last;
    logic                       iact_clear;
    logic                       abort;
    logic                       choose_upd;
    logic [NUM_PE*CHOOSE_W-1:0] choose_n;

    assign wght_clear = (state_q != WGHT) || wght_last || abort;
    assign iact_clear = (state_q != IACT) || iact_last || abort;

    pe_loader_chan #(
        .CHANNELS (NUM_GLB_WGHT),
        .WORD_W   (TRANS_BITWIDTH_WGHT),
        .LIMIT    (WGHT_ADDR_WORDS + WGHT_DATA_WORDS)
    ) u_wght (
        .clk      (clk_i),
        .rst      (rst_i),
        .active   (state_q == WGHT),
        .clear    (wght_clear),
        .in_data  (wght_in_data_i),
        .in_valid (wght_in_valid_i),
        .in_ready (wght_in_ready_o),
        .out_data (pe_wght_data_o),
        .enable   (pe_wght_enable_o),
        .pe_ready (pe_wght_ready_i),
        .xfer     (wght_xfer),
        .last     (wght_last)
    );

    pe_loader_chan #(
        .CHANNELS (NUM_GLB_IACT),
        .WORD_W   (TRANS_BITWIDTH_IACT),
        .LIMIT    (IACT_ADDR_WORDS + IACT_DATA_WORDS)
    ) u_iact (
        .clk      (clk_i),
        .rst      (rst_i),
        .active   (state_q == IACT),
        .clear    (iact_clear),
        .in_data  (iact_in_data_i),
        .in_valid (iact_in_valid_i),
        .in_ready (iact_in_ready_o),
        .out_data (pe_iact_data_o),
        .enable   (pe_iact_enable_o),
        .pe_ready (pe_iact_ready_i),
        .xfer     (iact_xfer),
        .last     (iact_last)
    );

`ifdef PE_LOADER_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] stall_q;
    logic              stalled;

    assign stalled = (pe_wght_enable_o[0] && !wght_xfer) || (pe_iact_enable_o[0] && !iact_xfer);
    assign abort   = ((state_q == WGHT) || (state_q == IACT)) && (stall_q == WDOG_W'(WDOG_CYCLES));

    // Consecutive stalled cycles with a word waiting on the cluster.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (abort || !stalled) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_q + WDOG_W'(1);
        end
    end

    // Sticky error, set on timeout and cleared by the next accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (abort) begin
            err_o <= 1'b1;
        end else if ((state_q == IDLE) && start_i) begin
            err_o <= 1'b0;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^{WDOG_CYCLES, wght_xfer};
    assign abort       = 1'b0;
    assign err_o       = 1'b0;
`endif

    // State and diagonal-pass registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            diag_q  <= '0;
        end else begin
            state_q <= state_n;
            diag_q  <= diag_n;
        end
    end

    // Next-state and pass sequencing.
    always_comb begin
        state_n = state_q;
        diag_n  = diag_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_n = WGHT;
                end
            end
            WGHT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (wght_last) begin
                    state_n = IACT;
                    diag_n  = '0;
                end
            end
            IACT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (iact_last) begin
                    if (diag_q == DIAG_W'(IACT_DIAGONALS - 1)) begin
                        state_n = COMPUTE;
                    end else begin
                        diag_n = diag_q + DIAG_W'(1);
                    end
                end
            end
            COMPUTE: state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Diagonal routing map for the upcoming state and pass.
    always_comb begin
        choose_n = '0;
        for (int c = 0; c < int'(PE_COLUMNS); c++) begin
            for (int r = 0; r < int'(PE_ROWS); r++) begin
                choose_n[(c*int'(PE_ROWS)+r)*int'(CHOOSE_W) +: CHOOSE_W] = CHOOSE_W'(IDLE_CODE);
                if ((state_n == IACT)
                    && ((c + r) >= int'(diag_n) * int'(NUM_GLB_IACT))
                    && ((c + r) < (int'(diag_n) + 1) * int'(NUM_GLB_IACT))) begin
                    choose_n[(c*int'(PE_ROWS)+r)*int'(CHOOSE_W) +: CHOOSE_W] =
                        CHOOSE_W'(c + r - int'(diag_n) * int'(NUM_GLB_IACT));
                end
            end
        end
    end

    // The map may only move when no iact word is held (or the held one leaves now).
    assign choose_upd = !pe_iact_enable_o[0] || iact_xfer || (state_n != IACT);

    // Registered status, compute and routing outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            compute_o     <= '0;
            iact_choose_o <= {NUM_PE{CHOOSE_W'(IDLE_CODE)}};
        end else begin
            busy_o    <= (state_n != IDLE);
            done_o    <= (state_n == DONE);
            compute_o <= {NUM_PE{state_n == COMPUTE}};
            if (choose_upd) begin
                iact_choose_o <= choose_n;
            end
        end
    end

endmodule

// File: tb/tb_pe_cluster_loader.sv
// Self-checking bench for pe_cluster_loader: cycle-exact timing table for one
// load, scoreboarded data on both streams, plus backpressure, start/reset and
// (with PE_LOADER_WATCHDOG_EN) watchdog sequences.
module tb_pe_cluster_loader;

    localparam int R   = 3;
    localparam int C   = 4;
    localparam int NI  = 3;
    localparam int NW  = 3;
    localparam int BW  = 24;
    localparam int CW  = 2;
    localparam int WDW = NW * BW;
    localparam int IDW = NI * BW;
    localparam int NPE = R * C;

    logic             clk;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             err;
    logic [WDW-1:0]   wght_in_data;
    logic             wght_in_valid;
    logic             wght_in_ready;
    logic [IDW-1:0]   iact_in_data;
    logic             iact_in_valid;
    logic             iact_in_ready;
    logic [WDW-1:0]   pe_wght_data;
    logic [NW-1:0]    pe_wght_enable;
    logic [NW-1:0]    pe_wght_ready;
    logic [IDW-1:0]   pe_iact_data;
    logic [NI-1:0]    pe_iact_enable;
    logic [NI-1:0]    pe_iact_ready;
    logic [NPE*CW-1:0] iact_choose;
    logic [NPE-1:0]   compute;

    pe_cluster_loader #(
        .WGHT_ADDR_WORDS (2),
        .WGHT_DATA_WORDS (4),
        .IACT_ADDR_WORDS (1),
        .IACT_DATA_WORDS (2),
        .IACT_DIAGONALS  (2),
        .WDOG_CYCLES     (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err),
        .wght_in_data_i   (wght_in_data),
        .wght_in_valid_i  (wght_in_valid),
        .wght_in_ready_o  (wght_in_ready),
        .iact_in_data_i   (iact_in_data),
        .iact_in_valid_i  (iact_in_valid),
        .iact_in_ready_o  (iact_in_ready),
        .pe_wght_data_o   (pe_wght_data),
        .pe_wght_enable_o (pe_wght_enable),
        .pe_wght_ready_i  (pe_wght_ready),
        .pe_iact_data_o   (pe_iact_data),
        .pe_iact_enable_o (pe_iact_enable),
        .pe_iact_ready_i  (pe_iact_ready),
        .iact_choose_o    (iact_choose),
        .compute_o        (compute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int w_xfers = 0;
    int i_xfers = 0;
    bit w_acc = 0;
    bit i_acc = 0;
    logic [WDW-1:0] wq[$];
    logic [IDW-1:0] iq[$];

    typedef struct {
        logic [NW-1:0]  wen;
        logic [NI-1:0]  ien;
        logic [NPE-1:0] comp;
        logic           dn;
        logic           bsy;
        int             pass;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [NPE*CW-1:0] exp_map(input int pass);
        logic [NPE*CW-1:0] m;
        int v;
        m = '0;
        for (int c = 0; c < C; c++) begin
            for (int r = 0; r < R; r++) begin
                v = c + r - pass * NI;
                if (pass < 0 || v < 0 || v >= NI) v = NI;
                m[(c*R+r)*CW +: CW] = CW'(v);
            end
        end
        return m;
    endfunction

    function automatic logic [CW-1:0] pe_ch(input int c, input int r);
        return iact_choose[(c*R+r)*CW +: CW];
    endfunction

    // Scoreboard: push words as they are accepted, pop and compare on transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (wght_in_valid && wght_in_ready) begin
                wq.push_back(wght_in_data);
                w_acc = 1;
            end
            if (iact_in_valid && iact_in_ready) begin
                iq.push_back(iact_in_data);
                i_acc = 1;
            end
            if ((&pe_wght_enable) && (&pe_wght_ready)) begin
                w_xfers++;
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wght_underflow: got transfer expected none (cycle %0d)", cycle);
                end else begin
                    check("wght_data", 128'(pe_wght_data), 128'(wq.pop_front()));
                end
            end
            if ((&pe_iact_enable) && (&pe_iact_ready)) begin
                i_xfers++;
                if (iq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL iact_underflow: got transfer expected none (cycle %0d)", cycle);
                end else begin
                    check("iact_data", 128'(pe_iact_data), 128'(iq.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        if (w_acc) begin
            wght_in_data = WDW'({$urandom, $urandom, $urandom});
            w_acc = 0;
        end
        if (i_acc) begin
            iact_in_data = IDW'({$urandom, $urandom, $urandom});
            i_acc = 0;
        end
    endtask

    task automatic clear_sb();
        wq.delete();
        iq.delete();
        w_xfers = 0;
        i_xfers = 0;
    endtask

    task automatic run_to_done(output bit seen);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (done) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic wait_iact(output bit seen);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (pe_iact_enable != '0) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wght_en"}, 128'(pe_wght_enable), 128'(0));
        check({tag, "_iact_en"}, 128'(pe_iact_enable), 128'(0));
        check({tag, "_busy"},    128'(busy),           128'(0));
        check({tag, "_done"},    128'(done),           128'(0));
        check({tag, "_compute"}, 128'(compute),        128'(0));
        check({tag, "_readies"}, 128'({wght_in_ready, iact_in_ready}), 128'(0));
        check({tag, "_choose"},  128'(iact_choose),    128'(exp_map(-1)));
        check({tag, "_data"},    128'({pe_wght_data, pe_iact_data}), 128'(0));
    endtask

    initial begin
        bit seen;
        int ndone;
        logic [WDW-1:0] held;
        int base;

        rst = 1; start = 0;
        wght_in_valid = 1; iact_in_valid = 1;
        wght_in_data = WDW'({$urandom, $urandom, $urandom});
        iact_in_data = IDW'({$urandom, $urandom, $urandom});
        pe_wght_ready = '1; pe_iact_ready = '1;

        // Reset state
        tick(); tick();
        check_reset_values("reset");
        check("reset_err", 128'(err), 128'(0));
        rst = 0;
        tick();
        clear_sb();

        // Expected cycle-by-cycle behaviour of one full load.
        for (int i = 0; i < 19; i++) begin
            tbl[i].wen  = (i >= 2 && i <= 7) ? '1 : '0;
            tbl[i].ien  = ((i >= 9 && i <= 11) || (i >= 13 && i <= 15)) ? '1 : '0;
            tbl[i].comp = (i == 16) ? '1 : '0;
            tbl[i].dn   = (i == 17);
            tbl[i].bsy  = (i >= 1 && i <= 17);
            tbl[i].pass = (i >= 8 && i <= 11) ? 0 : ((i >= 12 && i <= 15) ? 1 : -1);
        end

        start = 1;
        for (int i = 0; i < 19; i++) begin
            check($sformatf("c%0d_wght_en", i), 128'(pe_wght_enable), 128'(tbl[i].wen));
            check($sformatf("c%0d_iact_en", i), 128'(pe_iact_enable), 128'(tbl[i].ien));
            check($sformatf("c%0d_compute", i), 128'(compute),        128'(tbl[i].comp));
            check($sformatf("c%0d_done", i),    128'(done),           128'(tbl[i].dn));
            check($sformatf("c%0d_busy", i),    128'(busy),           128'(tbl[i].bsy));
            check($sformatf("c%0d_choose", i),  128'(iact_choose),    128'(exp_map(tbl[i].pass)));
            if (i == 9) begin
                check("pass0_pe00", 128'(pe_ch(0, 0)), 128'(0));
                check("pass0_pe11", 128'(pe_ch(1, 1)), 128'(2));
                check("pass0_pe32", 128'(pe_ch(3, 2)), 128'(3));
            end
            if (i == 13) begin
                check("pass1_pe12", 128'(pe_ch(1, 2)), 128'(0));
                check("pass1_pe32", 128'(pe_ch(3, 2)), 128'(2));
                check("pass1_pe00", 128'(pe_ch(0, 0)), 128'(3));
            end
            tick();
            start = 0;
        end
        check("full_wght_xfers", 128'(w_xfers), 128'(6));
        check("full_iact_xfers", 128'(i_xfers), 128'(6));
        check("full_queues_empty", 128'(wq.size() + iq.size()), 128'(0));

        // Backpressure: one channel not ready mid-data holds every channel.
        clear_sb();
        start = 1; tick(); start = 0;
        for (int k = 0; k < 50 && w_xfers < 3; k++) tick();
        check("bp_reached_mid_data", 128'(w_xfers), 128'(3));
        pe_wght_ready = 3'b101;
        held = pe_wght_data;
        base = w_xfers;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_data_stable", 128'(pe_wght_data), 128'(held));
            check("bp_enables_held", 128'(pe_wght_enable), 128'(3'b111));
        end
        check("bp_no_advance", 128'(w_xfers), 128'(base));
        pe_wght_ready = '1;
        run_to_done(seen);
        check("bp_done", 128'(seen), 128'(1));
        check("bp_wght_xfers", 128'(w_xfers), 128'(6));
        check("bp_iact_xfers", 128'(i_xfers), 128'(6));
        check("bp_queues_empty", 128'(wq.size() + iq.size()), 128'(0));
        tick();

        // start_i during IACT is ignored.
        clear_sb();
        start = 1; tick(); start = 0;
        wait_iact(seen);
        check("si_reached_iact", 128'(seen), 128'(1));
        start = 1; tick(); start = 0;
        run_to_done(seen);
        check("si_done", 128'(seen), 128'(1));
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("si_no_second_load", 128'(ndone), 128'(0));
        check("si_xfers", 128'({16'(w_xfers), 16'(i_xfers)}), 128'({16'd6, 16'd6}));

        // Reset pulse in the middle of IACT.
        clear_sb();
        start = 1; tick(); start = 0;
        wait_iact(seen);
        check("rst_reached_iact", 128'(seen), 128'(1));
        rst = 1;
        #1;
        check_reset_values("midrst");
        tick();
        rst = 0;
        tick();
        clear_sb();
        start = 1; tick(); start = 0;
        run_to_done(seen);
        check("rst_restart_done", 128'(seen), 128'(1));
        check("rst_restart_xfers", 128'({16'(w_xfers), 16'(i_xfers)}), 128'({16'd6, 16'd6}));
        check("rst_restart_queues", 128'(wq.size() + iq.size()), 128'(0));
        tick();

`ifdef PE_LOADER_WATCHDOG_EN
        // Watchdog: iact side never ready.
        clear_sb();
        pe_iact_ready = '0;
        start = 1; tick(); start = 0;
        seen = 0; ndone = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (done) ndone++;
            if (err) begin
                seen = 1;
                break;
            end
        end
        check("wd_err_set", 128'(seen), 128'(1));
        check("wd_no_done", 128'(ndone), 128'(0));
        tick();
        check("wd_idle", 128'(busy), 128'(0));
        check("wd_enables_low", 128'(pe_iact_enable), 128'(0));
        check("wd_err_sticky", 128'(err), 128'(1));
        pe_iact_ready = '1;
        clear_sb();
        start = 1; tick(); start = 0;
        check("wd_err_cleared", 128'(err), 128'(0));
        run_to_done(seen);
        check("wd_recover_done", 128'(seen), 128'(1));
        check("wd_recover_xfers", 128'({16'(w_xfers), 16'(i_xfers)}), 128'({16'd6, 16'd6}));
`else
        check("no_wdog_err", 128'(err), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
